addsub_seq_ctrl: RTL and testbench
==================================

# addsub_seq_ctrl

Sequencing controller that performs WIDTH-bit add/subtract by running operands through a single 4-bit ripple-carry adder/subtractor slice, one nibble per cycle, least-significant nibble first. A registered carry chains the nibbles. A start/busy/done handshake fronts the block. It sits between a requester such as an ALU front-end or a test sequencer and the shared 4-bit add/sub datapath, so wide arithmetic needs no wide adder.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  W  operand A; latched with start.
- b  input  W  operand B; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.
- result  output  W  sum/difference, held until next accepted start.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow; present only with ADDSUB_SEQ_OVF_EN.

## Operation
- FSM states and transitions: IDLE -> RUN when start=1; RUN -> DONE after nibble NIBBLES-1; DONE -> IDLE unconditionally.
- IDLE, start=1: latch a, b, op_sub; clear nibble index to 0; set carry register to op_sub; clear result to 0.
- RUN, each cycle on nibble i:
  - Slice inputs are a[4i+3:4i], b[4i+3:4i], ctrl = op_sub, carry-in = carry register.
  - Slice internally inverts b when ctrl=1.
  - Write the slice sum into result[4i+3:4i]; load the slice MSB carry into the carry register.
  - Increment i.
- Subtract is two's complement: a + ~b + 1, with the +1 supplied as carry-in of nibble 0.
- cout is the final carry register, updated when entering DONE.
- Wrap-around: results are modulo 2^W, e.g. 0xFFFF+1 = 0x0000 with cout=1.
- Boundary conditions:
  - start while busy or in DONE: ignored; no queueing.
  - op_sub, a, b changing during RUN: no effect, because operands are latched.
  - NIBBLES=1: RUN lasts exactly one cycle.
  - Reset asserted mid-operation: immediate return to IDLE; all outputs go to reset values; no done pulse.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0; state IDLE; index 0; carry register 0.

## Timing
- start sampled high at edge k:
  - busy is 1 from edge k until edge k+NIBBLES.
  - done is 1 for exactly one cycle, from edge k+NIBBLES to edge k+NIBBLES+1.
- The earliest next accepted start is at edge k+NIBBLES+1, giving a throughput of one operation per NIBBLES+1 cycles.
- result nibble i becomes valid at edge k+i+1. The full result and cout are valid when done=1 and stay stable until the next accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ADDSUB_SEQ_OVF_EN defined:
  - ovf port exists.
  - ovf = (carry into MSB bit) XOR (carry out of MSB bit) of the last nibble, taken from the slice's per-bit carry vector.
  - ovf is updated with cout and reset to 0.
- ADDSUB_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

## Structure
- Package addsub_seq_pkg contains:
  - NIBBLE_W = 4.
  - The state enum (ST_IDLE, ST_RUN, ST_DONE).
  - The index width function clog2(NIBBLES).
- Sub-module addsub4_slice: the combinational 4-bit ripple-carry add/sub.
  - Ports: a[3:0], b[3:0], ctrl, cin; s[3:0], c[3:0].
  - c is the per-bit carry-out vector; c[3] is the MSB carry.
  - Instantiated once.

## Test plan
Each case uses NIBBLES=4.
- Add: a=0x1234, b=0x0FFF, op_sub=0 -> result=0x2233, cout=0; done exactly 4 cycles after the start edge; busy high for 4 cycles.
- Subtract without borrow: a=0x0005, b=0x0003, op_sub=1 -> result=0x0002, cout=1.
- Subtract with borrow and wrap: a=0x0003, b=0x0005, op_sub=1 -> result=0xFFFE, cout=0.
- Wrap and overflow:
  - a=0xFFFF, b=0x0001, add -> result=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001, add -> result=0x8000, cout=0, ovf=1 (ovf checked only with ADDSUB_SEQ_OVF_EN).
- Handshake: pulse start again during RUN with different operands -> ignored; first result is delivered; the new start is accepted only after returning to IDLE.
- Reset mid-op: deassert rst_n at RUN nibble 2 -> busy, done, result and cout are 0 immediately; no done pulse follows; the next start completes normally.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub controller.
// Holds slice width, FSM state enum and index-width helpers.
package addsub_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single-nibble build still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_slice.sv
// Combinational 4-bit ripple-carry add/subtract slice.
// Ports: a, b, ctrl (1 = subtract), cin -> s, c (per-bit carry-out).
import addsub_seq_pkg::*;

module addsub4_slice (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ctrl,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic [NIBBLE_W-1:0] c
);

  logic [NIBBLE_W-1:0] bx;
  logic                k;

  assign bx = b ^ {NIBBLE_W{ctrl}};

  always_comb begin
    s = '0;
    c = '0;
    k = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ bx[i] ^ k;
      c[i] = (a[i] & bx[i]) | (a[i] & k) | (bx[i] & k);
      k    = c[i];
    end
  end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Wide add/sub by running one 4-bit slice over the operands LSB nibble first.
// Ports: clk, rst_n, start/op_sub/a/b in; busy, done, result, cout
// out; ovf out only when ADDSUB_SEQ_OVF_EN is defined.
import addsub_seq_pkg::*;

module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        op_sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        cout
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic                        ovf
`endif
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);

  state_t              st;
  logic [IW-1:0]       idx;
  logic                cy;
  logic                sub_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [NIBBLE_W-1:0] sa;
  logic [NIBBLE_W-1:0] sb;
  logic [NIBBLE_W-1:0] s;
  logic [NIBBLE_W-1:0] c;
  logic                last;

  assign sa   = a_q[NIBBLE_W*idx +: NIBBLE_W];
  assign sb   = b_q[NIBBLE_W*idx +: NIBBLE_W];
  assign last = (idx == IW'(NIBBLES - 1));

  addsub4_slice u_slice (
    .a    (sa),
    .b    (sb),
    .ctrl (sub_q),
    .cin  (cy),
    .s    (s),
    .c    (c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      idx    <= '0;
      cy     <= 1'b0;
      sub_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            st     <= ST_RUN;
            a_q    <= a;
            b_q    <= b;
            sub_q  <= op_sub;
            idx    <= '0;
            // Subtract's +1 enters as carry-in of nibble 0.
            cy     <= op_sub;
            result <= '0;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          result[NIBBLE_W*idx +: NIBBLE_W] <= s;
          cy <= c[NIBBLE_W-1];
          if (last) begin
            st   <= ST_DONE;
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            cout <= c[NIBBLE_W-1];
`ifdef ADDSUB_SEQ_OVF_EN
            ovf  <= c[NIBBLE_W-1] ^ c[NIBBLE_W-2];
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          st   <= ST_IDLE;
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (NIBBLES=4).
// Table vectors, random ops vs arithmetic model, handshake and reset cases.
module tb_addsub_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf_s;

  int checks;
  int errors;

  addsub_seq_ctrl #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    .ovf    (ovf_s)
`endif
  );

`ifndef ADDSUB_SEQ_OVF_EN
  assign ovf_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic reference.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic ms, output logic [W-1:0] r,
                       output logic c, output logic o);
    longint unsigned full;
    longint signed   sa;
    longint signed   sb;
    longint signed   sr;
    if (ms) full = longint'(ma) + longint'((~mb) & 16'hFFFF) + 1;
    else    full = longint'(ma) + longint'(mb);
    r  = full[W-1:0];
    c  = full[W];
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sr = ms ? sa - sb : sa + sb;
    o  = (sr > 32767) || (sr < -32768);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic ts, input logic [W-1:0] er,
                        input logic ec, input logic eo, input string nm);
    int n;
    int bcnt;
    bit seen;
    @(negedge clk);
    a = ta;
    b = tb2;
    op_sub = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    op_sub = 1'($urandom);
    n = 0;
    bcnt = 0;
    seen = 0;
    if (busy) bcnt++;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        n = i;
      end else if (busy) begin
        bcnt++;
      end
    end
    if (!seen) begin
      chk({nm, " timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({nm, " latency"}, 64'(n), 64'(N));
    chk({nm, " busy_cycles"}, 64'(bcnt), 64'(N));
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " cout"}, 64'(cout), 64'(ec));
`ifdef ADDSUB_SEQ_OVF_EN
    chk({nm, " ovf"}, 64'(ovf_s), 64'(eo));
`else
    if (eo === 1'bx) chk({nm, " ovf_x"}, 64'(ovf_s), 64'd0);
`endif
    @(posedge clk);
    #1;
    chk({nm, " done_drop"}, 64'(done), 64'd0);
    chk({nm, " hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           dcnt;
    bit           seen;
    int           n;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;

    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst cout", 64'(cout), 64'd0);
    chk("rst ovf", 64'(ovf_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].r, tbl[i].c,
             tbl[i].o, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; end
      if (i == 1) begin ra = 16'h0000; rb = 16'h0000; rs = 1'b1; end
      model(ra, rb, rs, er, ec, eo);
      run_op(ra, rb, rs, er, ec, eo, $sformatf("rnd%0d", i));
    end

    // Handshake: second start during RUN must be dropped.
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    op_sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    op_sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        n = i;
      end
    end
    chk("hs seen_done", 64'(seen), 64'd1);
    chk("hs latency", 64'(n), 64'(N - 2));
    chk("hs result", 64'(result), 64'h3333);
    chk("hs cout", 64'(cout), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      dcnt += int'(busy) + int'(done);
    end
    chk("hs no_queue", 64'(dcnt), 64'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "hs next");

    // Reset in the cycle processing nibble 2.
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    op_sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid busy", 64'(busy), 64'd0);
    chk("mid done", 64'(done), 64'd0);
    chk("mid result", 64'(result), 64'd0);
    chk("mid cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      dcnt += int'(done) + int'(busy);
    end
    chk("mid no_done", 64'(dcnt), 64'd0);
    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
